ipm_host_initiator: RTL and testbench

MCU-side bus master for the IPM 8-bit host port; it is the initiator whose responder is the ipm block inside each ipm_ID* wrapper.
Accepts word-level commands (WRITE word, READ word, START) from a local controller or testbench sequencer.
Serialises each command into byte-wide register cycles on addressMCU/rdMCU/wrMCU/dataMCU.
Edge-detects intMCU and presents it as a sticky interrupt flag.

---
 rtl/ipm_host_pkg.sv | 74 +++++++
 rtl/ipm_bus_cycle.sv | 94 +++++++++
 rtl/ipm_host_initiator.sv | 163 ++++++++++++++++
 tb/tb_ipm_host_initiator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ipm_host_pkg.sv
// Shared encodings for the IPM host-port initiator: ops, register map, FSM states and the
// per-step bus cycle table that the sequencer walks through.
package ipm_host_pkg;

   typedef enum logic [1:0] {
      OpWrite   = 2'b00,
      OpRead    = 2'b01,
      OpStart   = 2'b10,
      OpIllegal = 2'b11
   } op_e;

   localparam logic [3:0] AddrData0 = 4'h0;
   localparam logic [3:0] AddrConf  = 4'h4;
   localparam logic [3:0] AddrCtrl  = 4'h5;

   localparam logic [7:0] CtrlStart  = 8'h01;
   localparam logic [7:0] CtrlWrWord = 8'h02;
   localparam logic [7:0] CtrlRdWord = 8'h04;

   // WRITE and READ both take six byte cycles (steps 0..5); START takes one
   localparam logic [2:0] LastWordStep = 3'd5;

   typedef enum logic [1:0] {StIdle, StSeq, StDone} seq_state_e;
   typedef enum logic [1:0] {BcIdle, BcSetup, BcStrobe, BcEnd} bc_state_e;

   typedef struct packed {
      logic       write;
      logic [3:0] addr;
      logic [7:0] data;
   } bus_step_t;

   function automatic logic [2:0] last_step(op_e op);
      return (op == OpStart) ? 3'd0 : LastWordStep;
   endfunction

   // Byte cycle issued at step idx of a command
   function automatic bus_step_t step_of(op_e op, logic [2:0] idx, logic [7:0] conf,
                                         logic [31:0] wdata);
      bus_step_t  s;
      logic [2:0] k;
      s = '{write: 1'b1, addr: AddrCtrl, data: CtrlStart};
      k = 3'd0;
      case (op)
         OpWrite: begin
            if (idx == 3'd0) begin
               s.addr = AddrConf;
               s.data = conf;
            end else if (idx <= 3'd4) begin
               k      = idx - 3'd1;
               s.addr = AddrData0 + {1'b0, k};
               s.data = wdata[{k[1:0], 3'b000} +: 8];
            end else begin
               s.data = CtrlWrWord;
            end
         end
         OpRead: begin
            if (idx == 3'd0) begin
               s.addr = AddrConf;
               s.data = conf;
            end else if (idx == 3'd1) begin
               s.data = CtrlRdWord;
            end else begin
               k       = idx - 3'd2;
               s.write = 1'b0;
               s.addr  = AddrData0 + {1'b0, k};
               s.data  = 8'h00;
            end
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ipm_bus_cycle.sv
// Single byte-wide register cycle on the IPM host port.
// Write: SETUP, WR_CYC strobe cycles, HOLD.  Read: SETUP, RD_CYC strobe cycles, TURN.
// A new start may be issued in the HOLD/TURN cycle so byte cycles run back-to-back.
module ipm_bus_cycle
   import ipm_host_pkg::*;
#(
   parameter int unsigned WR_CYC = 2,
   parameter int unsigned RD_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic       start,
   input  logic       start_write,
   input  logic [3:0] start_addr,
   input  logic [7:0] start_data,
   output logic       cycle_done,
   output logic [7:0] rd_byte,
   output logic [3:0] addr,
   output logic       rd,
   output logic       wr,
   output logic [7:0] data_o,
   output logic       oe,
   input  logic [7:0] data_i
);

   localparam logic [3:0] WrLast = 4'(WR_CYC - 1);
   localparam logic [3:0] RdLast = 4'(RD_CYC - 1);

   bc_state_e  state_q;
   logic       write_q;
   logic [3:0] cnt_q;
   logic [3:0] addr_q;
   logic [7:0] data_q;
   logic       oe_q;
   logic       rd_q;
   logic       wr_q;
   logic [7:0] rd_byte_q;

   // Phase sequencer with registered strobes; pad data captured on the last strobe cycle
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_q   <= BcIdle;
         write_q   <= 1'b0;
         cnt_q     <= 4'd0;
         addr_q    <= 4'd0;
         data_q    <= 8'd0;
         oe_q      <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         rd_byte_q <= 8'd0;
      end else if (start) begin
         state_q <= BcSetup;
         write_q <= start_write;
         addr_q  <= start_addr;
         data_q  <= start_data;
         oe_q    <= start_write;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         unique case (state_q)
            BcIdle: ;
            BcSetup: begin
               state_q <= BcStrobe;
               cnt_q   <= write_q ? WrLast : RdLast;
               wr_q    <= write_q;
               rd_q    <= ~write_q;
            end
            BcStrobe: begin
               if (cnt_q == 4'd0) begin
                  state_q <= BcEnd;
                  wr_q    <= 1'b0;
                  rd_q    <= 1'b0;
                  if (!write_q) rd_byte_q <= data_i;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            BcEnd: begin
               state_q <= BcIdle;
               oe_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cycle_done = (state_q == BcEnd);
   assign rd_byte    = rd_byte_q;
   assign addr       = addr_q;
   assign rd         = rd_q;
   assign wr         = wr_q;
   assign data_o     = data_q;
   assign oe         = oe_q;

endmodule

// File: rtl/ipm_host_initiator.sv
// MCU-side initiator for the IPM 8-bit host port: turns word commands into byte register
// cycles and presents intMCU as a sticky edge-detected interrupt flag.
module ipm_host_initiator
   import ipm_host_pkg::*;
#(
   parameter int unsigned WR_CYC     = 2,
   parameter int unsigned RD_CYC     = 2,
   parameter int unsigned CONF_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_a,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [CONF_WIDTH-1:0] cmd_conf,
   input  logic [31:0]           cmd_wdata,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           rsp_rdata,
   output logic [3:0]            addressMCU,
   output logic                  rdMCU,
   output logic                  wrMCU,
   output logic [7:0]            dataMCU_o,
   output logic                  dataMCU_oe,
   input  logic [7:0]            dataMCU_i,
   input  logic                  intMCU,
   output logic                  irq_pending,
   input  logic                  irq_ack
);

   seq_state_e            state_q;
   op_e                   op_q;
   logic [CONF_WIDTH-1:0] conf_q;
   logic [31:0]           wdata_q;
   logic [2:0]            idx_q;
   logic                  ready_q;
   logic                  done_q;
   logic                  err_q;
   logic [31:0]           rsp_q;
   logic [31:0]           shadow_q;
   logic                  int_q;
   logic                  irq_q;

   op_e       cmd_op_e;
   logic      accept;
   logic      bc_start;
   logic      cycle_done;
   logic      last;
   logic [1:0] rd_k;
   logic [7:0] rd_byte;
   bus_step_t step;

   assign cmd_op_e = op_e'(cmd_op);
   assign accept   = cmd_valid & ready_q;
   assign last     = (idx_q == last_step(op_q));
   assign rd_k     = 2'(idx_q - 3'd2);

   // Next byte cycle: step 0 straight from the command inputs, later steps from latched fields
   always_comb begin
      bc_start = 1'b0;
      step     = step_of(op_q, idx_q + 3'd1, 8'(conf_q), wdata_q);
      if (accept && cmd_op_e != OpIllegal) begin
         bc_start = 1'b1;
         step     = step_of(cmd_op_e, 3'd0, 8'(cmd_conf), cmd_wdata);
      end else if (state_q == StSeq && cycle_done && !last) begin
         bc_start = 1'b1;
      end
   end

   // Command FSM with registered ready/done/err and READ word assembly
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_q  <= StIdle;
         op_q     <= OpWrite;
         conf_q   <= '0;
         wdata_q  <= 32'd0;
         idx_q    <= 3'd0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rsp_q    <= 32'd0;
         shadow_q <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q    <= cmd_op_e;
                  conf_q  <= cmd_conf;
                  wdata_q <= cmd_wdata;
                  idx_q   <= 3'd0;
                  ready_q <= 1'b0;
                  if (cmd_op_e == OpIllegal) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= StSeq;
                  end
               end
            end
            StSeq: begin
               if (cycle_done) begin
                  if (op_q == OpRead && idx_q >= 3'd2) begin
                     shadow_q[{rd_k, 3'b000} +: 8] <= rd_byte;
                     if (last) rsp_q <= {rd_byte, shadow_q[23:0]};
                  end
                  if (last) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Interrupt edge detect; a fresh edge wins over a simultaneous acknowledge
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         int_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         int_q <= intMCU;
         irq_q <= (intMCU & ~int_q) | (irq_q & ~irq_ack);
      end
   end

   ipm_bus_cycle #(
      .WR_CYC (WR_CYC),
      .RD_CYC (RD_CYC)
   ) u_bus_cycle (
      .clk         (clk),
      .rst_a       (rst_a),
      .start       (bc_start),
      .start_write (step.write),
      .start_addr  (step.addr),
      .start_data  (step.data),
      .cycle_done  (cycle_done),
      .rd_byte     (rd_byte),
      .addr        (addressMCU),
      .rd          (rdMCU),
      .wr          (wrMCU),
      .data_o      (dataMCU_o),
      .oe          (dataMCU_oe),
      .data_i      (dataMCU_i)
   );

   assign cmd_ready   = ready_q;
   assign done        = done_q;
   assign err         = err_q;
   assign rsp_rdata   = rsp_q;
   assign irq_pending = irq_q;

endmodule

// File: tb/tb_ipm_host_initiator.sv
// Self-checking bench for ipm_host_initiator: directed and random commands compared against
// a transaction-list model of the host-port protocol, plus reset and interrupt checks.
module tb_ipm_host_initiator;

   localparam int unsigned WR_CYC     = 2;
   localparam int unsigned RD_CYC     = 2;
   localparam int unsigned CONF_WIDTH = 5;

   logic                  clk = 1'b0;
   logic                  rst_a = 1'b1;
   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic [1:0]            cmd_op = 2'd0;
   logic [CONF_WIDTH-1:0] cmd_conf = '0;
   logic [31:0]           cmd_wdata = 32'd0;
   logic                  done;
   logic                  err;
   logic [31:0]           rsp_rdata;
   logic [3:0]            addressMCU;
   logic                  rdMCU;
   logic                  wrMCU;
   logic [7:0]            dataMCU_o;
   logic                  dataMCU_oe;
   logic [7:0]            dataMCU_i;
   logic                  intMCU = 1'b0;
   logic                  irq_pending;
   logic                  irq_ack = 1'b0;

   // Responder model: byte registers returned on read strobes
   logic [7:0] resp_mem [16];

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model_rsp = 32'd0;
   logic [12:0] exp_q[$];
   logic [12:0] obs_q[$];

   always #5 clk = ~clk;

   always_comb begin
      dataMCU_i = 8'h00;
      if (rdMCU) dataMCU_i = resp_mem[addressMCU];
   end

   ipm_host_initiator #(
      .WR_CYC     (WR_CYC),
      .RD_CYC     (RD_CYC),
      .CONF_WIDTH (CONF_WIDTH)
   ) dut (
      .clk         (clk),
      .rst_a       (rst_a),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_conf    (cmd_conf),
      .cmd_wdata   (cmd_wdata),
      .done        (done),
      .err         (err),
      .rsp_rdata   (rsp_rdata),
      .addressMCU  (addressMCU),
      .rdMCU       (rdMCU),
      .wrMCU       (wrMCU),
      .dataMCU_o   (dataMCU_o),
      .dataMCU_oe  (dataMCU_oe),
      .dataMCU_i   (dataMCU_i),
      .intMCU      (intMCU),
      .irq_pending (irq_pending),
      .irq_ack     (irq_ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Expected bus transactions {is_write, addr, data} and done latency for one command
   task automatic model_cmd(input logic [1:0] op, input logic [7:0] conf, input logic [31:0] wd,
                            output int lat);
      exp_q.delete();
      case (op)
         2'd0: begin
            exp_q.push_back({1'b1, 4'h4, conf});
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 4'(k), 8'(wd >> (8 * k))});
            exp_q.push_back({1'b1, 4'h5, 8'h02});
         end
         2'd1: begin
            exp_q.push_back({1'b1, 4'h4, conf});
            exp_q.push_back({1'b1, 4'h5, 8'h04});
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 4'(k), 8'h00});
         end
         2'd2: exp_q.push_back({1'b1, 4'h5, 8'h01});
         default: ;
      endcase
      lat = 1;
      foreach (exp_q[i]) lat += exp_q[i][12] ? int'(WR_CYC) + 2 : int'(RD_CYC) + 2;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [CONF_WIDTH-1:0] conf,
                          input logic [31:0] wd, input bit hold_valid);
      int   lat;
      int   wr_len;
      int   rd_len;
      logic prev_wr;
      logic prev_rd;
      logic got;
      @(negedge clk);
      check("ready_idle", 32'(cmd_ready), 32'd1);
      check("done_pulse", 32'(done), 32'd0);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_conf  = conf;
      cmd_wdata = wd;
      model_cmd(op, 8'(conf), wd, lat);
      obs_q.delete();
      wr_len  = 0;
      rd_len  = 0;
      prev_wr = 1'b0;
      prev_rd = 1'b0;
      got     = 1'b0;
      @(posedge clk);
      for (int n = 1; n <= 200 && !got; n++) begin
         @(negedge clk);
         if (!hold_valid) cmd_valid = 1'b0;
         if (rdMCU) begin
            check("oe_during_rd", 32'(dataMCU_oe), 32'd0);
            check("wr_during_rd", 32'(wrMCU), 32'd0);
         end
         if (wrMCU && !prev_wr) obs_q.push_back({1'b1, addressMCU, dataMCU_o});
         if (rdMCU && !prev_rd) obs_q.push_back({1'b0, addressMCU, 8'h00});
         if (wrMCU) wr_len++;
         else if (prev_wr) begin
            check("wr_pulse_len", 32'(wr_len), 32'(WR_CYC));
            wr_len = 0;
         end
         if (rdMCU) rd_len++;
         else if (prev_rd) begin
            check("rd_pulse_len", 32'(rd_len), 32'(RD_CYC));
            rd_len = 0;
         end
         prev_wr = wrMCU;
         prev_rd = rdMCU;
         if (done) begin
            got = 1'b1;
            if (op == 2'd1)
               model_rsp = {resp_mem[3], resp_mem[2], resp_mem[1], resp_mem[0]};
            check("done_latency", 32'(n), 32'(lat));
            check("err", 32'(err), 32'(op == 2'd3));
            check("rsp_rdata", rsp_rdata, model_rsp);
         end else begin
            check("ready_busy", 32'(cmd_ready), 32'd0);
         end
      end
      check("done_seen", 32'(got), 32'd1);
      check("txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check($sformatf("txn%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) resp_mem[i] = 8'h00;

      // Power-on reset
      #1 rst_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rsp", rsp_rdata, 32'd0);
      check("rst_bus", {18'd0, addressMCU, rdMCU, wrMCU, dataMCU_o, dataMCU_oe}, 32'd0);
      check("rst_irq", 32'(irq_pending), 32'd0);
      @(negedge clk);
      rst_a = 1'b1;

      // Directed commands
      run_cmd(2'd0, 5'd3, 32'hA1B2C3D4, 1'b0);
      resp_mem[0] = 8'h11;
      resp_mem[1] = 8'h22;
      resp_mem[2] = 8'h33;
      resp_mem[3] = 8'h44;
      run_cmd(2'd1, 5'd7, 32'h0, 1'b0);
      check("read_word", rsp_rdata, 32'h44332211);
      run_cmd(2'd2, 5'd0, 32'h0, 1'b1);
      run_cmd(2'd2, 5'd0, 32'h0, 1'b0);
      run_cmd(2'd3, 5'd1, 32'h0, 1'b0);

      // Reset in the middle of a WRITE strobe
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_conf  = 5'd9;
      cmd_wdata = 32'h12345678;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      check("mid_wr_strobe", 32'(wrMCU), 32'd1);
      rst_a = 1'b0;
      #1;
      check("abort_wr", 32'(wrMCU), 32'd0);
      check("abort_oe", 32'(dataMCU_oe), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      model_rsp = 32'd0;
      check("abort_rsp", rsp_rdata, model_rsp);
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      rst_a = 1'b1;

      // Randomised commands
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 4; i++) resp_mem[i] = 8'($urandom);
         run_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, 1'b0);
      end

      // Interrupt flag
      @(negedge clk);
      check("irq_idle", 32'(irq_pending), 32'd0);
      intMCU = 1'b1;
      @(negedge clk);
      check("irq_rise", 32'(irq_pending), 32'd1);
      intMCU = 1'b0;
      @(negedge clk);
      check("irq_sticky", 32'(irq_pending), 32'd1);
      intMCU  = 1'b1;
      irq_ack = 1'b1;
      @(negedge clk);
      check("irq_ack_vs_edge", 32'(irq_pending), 32'd1);
      @(negedge clk);
      check("irq_ack_clear", 32'(irq_pending), 32'd0);
      irq_ack = 1'b0;
      @(negedge clk);
      check("irq_level_no_set", 32'(irq_pending), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
